// File: rtl/flop_2clk_tx.sv
// flop_2clk_tx: divides clk into tx_clk and launches one buffered word per tx_clk period; FLOP_2CLK_TX_CLK_GATE_EN parks tx_clk low when idle.
// Latency: a word pushed at edge N launches at the first tx_clk fall at or after edge N+1 (gated: rise HALF_PERIOD clocks after the push).
// Backpressure: in_ready drops while the 2-entry buffer is full; stall freezes divider and launches but still accepts pushes.

module flop_2clk_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    // Generic small FIFO with registered count; no bypass path from push to pop_dat.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

module flop_2clk_tx #(
    parameter int WIDTH       = 32,
    parameter int HALF_PERIOD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_clk,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data
);
    localparam int CW = 8;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t            phase_q;
    phase_t            phase_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              fall;
    logic              park;
    logic              wrap;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  head_dat;

    assign wrap = (cnt_q == CW'(HALF_PERIOD - 1));

`ifdef FLOP_2CLK_TX_CLK_GATE_EN
    // Nothing in flight and nothing queued: hold the divider so tx_clk stays parked low.
    assign park = (phase_q == PH_LOW) && !tx_valid && fifo_empty;
`else
    assign park = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        fall    = 1'b0;
        if (!stall) begin
            if (park) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d   = '0;
                phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
                fall    = (phase_q == PH_HIGH);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_LOW;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_clk   = (phase_q == PH_HIGH);
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    // Pop looks only at the registered empty flag, so a same-cycle push never launches early.
    assign pop      = fall && !fifo_empty && !flush;

    flop_2clk_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_dat (in_data),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (fall) begin
            if (!fifo_empty) begin
                tx_valid <= 1'b1;
                tx_data  <= head_dat;
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_flop_2clk_tx.sv
// Bench for flop_2clk_tx (WIDTH=8, HALF_PERIOD=4): directed link scenarios then random traffic against a queue model.
module tb_flop_2clk_tx;
    localparam int W  = 8;
    localparam int HP = 4;
`ifdef FLOP_2CLK_TX_CLK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         tx_clk;
    logic         tx_valid;
    logic [W-1:0] tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: position within the current tx_clk phase, the phase level, and a word queue.
    logic         m_clk = 1'b0;
    logic         m_vld = 1'b0;
    logic [W-1:0] m_dat = '0;
    int           m_pos = 0;
    logic [W-1:0] m_q[$];
    logic         m_acc = 1'b0;
    int           cyc = 0;

    flop_2clk_tx #(.WIDTH(W), .HALF_PERIOD(HP)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_clk   (tx_clk),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic fl, input logic v,
                        input logic [W-1:0] d);
        logic fall_now;
        logic park_now;
        logic push_now;
        reset    = r;
        stall    = st;
        flush    = fl;
        in_valid = v;
        in_data  = d;
        push_now = !r && !fl && v && (m_q.size() < 2);
        park_now = GATE && !m_clk && !m_vld && (m_q.size() == 0);
        fall_now = !st && m_clk && (m_pos == HP - 1);
        m_acc    = push_now;
        @(posedge clk);
        if (r) begin
            m_clk = 1'b0;
            m_pos = 0;
            m_vld = 1'b0;
            m_dat = '0;
            m_q.delete();
            cyc   = 0;
        end else begin
            cyc++;
            if (!st) begin
                if (park_now) m_pos = 0;
                else if (m_pos == HP - 1) begin
                    m_pos = 0;
                    m_clk = !m_clk;
                end else m_pos++;
            end
            if (fl) begin
                m_vld = 1'b0;
                m_dat = '0;
                m_q.delete();
            end else begin
                if (fall_now) begin
                    if (m_q.size() > 0) begin
                        m_dat = m_q.pop_front();
                        m_vld = 1'b1;
                    end else m_vld = 1'b0;
                end
                if (push_now) m_q.push_back(d);
            end
        end
        @(negedge clk);
        chk1("tx_clk", tx_clk, m_clk);
        chk1("tx_valid", tx_valid, m_vld);
        chk8("tx_data", tx_data, m_dat);
        chk1("in_ready", in_ready, m_q.size() < 2);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic got;
        int   e;

        // Reset state
        do_reset();
        chk1("rst_clk", tx_clk, 1'b0);
        chk1("rst_vld", tx_valid, 1'b0);
        chk8("rst_dat", tx_data, 8'h00);
        chk1("rst_rdy", in_ready, 1'b1);

        // Idle link after reset
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifndef FLOP_2CLK_TX_CLK_GATE_EN
            chk1("t1_clk", tx_clk, ((k / 4) % 2) == 1);
`endif
            chk1("t1_vld", tx_valid, 1'b0);
            chk8("t1_dat", tx_data, 8'h00);
        end

        // Single word
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        for (int k = 2; k <= 17; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifndef FLOP_2CLK_TX_CLK_GATE_EN
            chk1("t2_vld", tx_valid, (k >= 8) && (k < 16));
            chk8("t2_dat", tx_data, (k >= 8) ? 8'hA5 : 8'h00);
`endif
        end

        // Three back-to-back words, buffer fills
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
        chk1("t3_full", in_ready, 1'b0);
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
            if (m_acc) got = 1'b1;
        end
        chk1("t3_acc33", got, 1'b1);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifndef FLOP_2CLK_TX_CLK_GATE_EN
            if (cyc == 16) chk8("t3_second", tx_data, 8'h22);
            if (cyc == 24) chk8("t3_third", tx_data, 8'h33);
`endif
        end

        // Stall during HIGH phase
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        for (int g = 0; g < 20 && !m_clk; g++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk1("t4_high", tx_clk, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, W'($urandom));
            chk1("t4_clk_hold", tx_clk, 1'b1);
        end
        chk1("t4_full_in_stall", in_ready, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Flush with two buffered words and a live word
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2);
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
            if (m_acc) got = 1'b1;
        end
        chk1("t5_acc", got, 1'b1);
        chk1("t5_vld_pre", tx_valid, 1'b1);
        chk1("t5_full_pre", in_ready, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        chk1("t5_rdy", in_ready, 1'b1);
        chk1("t5_vld", tx_valid, 1'b0);
        chk8("t5_dat", tx_data, 8'h00);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);

`ifdef FLOP_2CLK_TX_CLK_GATE_EN
        // Parked clock released by a push
        do_reset();
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk1("t6_park", tx_clk, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        e = cyc;
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            if (cyc == e + 3) chk1("t6_pre_rise", tx_clk, 1'b0);
            if (cyc == e + 4) chk1("t6_rise", tx_clk, 1'b1);
            if (cyc == e + 8) chk8("t6_dat", tx_data, 8'h5A);
            if (cyc > e + 16) chk1("t6_repark", tx_clk, 1'b0);
        end
`else
        e = 0;
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 150) == 0, ($urandom % 8) == 0, ($urandom % 40) == 0,
                 ($urandom % 2) == 0, W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
